// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display receiver.
// Segment patterns are active-low, ordered bit6=g .. bit0=a.
package ssd_pkg;

  localparam int N_DIGITS_DEF = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_seg2hex.sv
// Combinational decode of an active-low segment pattern into a hex nibble.
// hit: pattern is one of the 16 hex glyphs; blank: all segments off.
module ssd_seg2hex
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       hit,
  output logic       blank
);

  // Pattern lookup; anything unlisted is unrecognised
  always_comb begin
    nib   = 4'h0;
    hit   = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0: nib = 4'h0;
      SEG_1: nib = 4'h1;
      SEG_2: nib = 4'h2;
      SEG_3: nib = 4'h3;
      SEG_4: nib = 4'h4;
      SEG_5: nib = 4'h5;
      SEG_6: nib = 4'h6;
      SEG_7: nib = 4'h7;
      SEG_8: nib = 4'h8;
      SEG_9: nib = 4'h9;
      SEG_A: nib = 4'hA;
      SEG_B: nib = 4'hB;
      SEG_C: nib = 4'hC;
      SEG_D: nib = 4'hD;
      SEG_E: nib = 4'hE;
      SEG_F: nib = 4'hF;
      SEG_BLANK: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_rx.sv
// Seven-segment display bus receiver: samples a multiplexed active-low
// anode/cathode bus, waits for a (digit, pattern) pair to be stable for
// STABLE_CNT samples and commits the decoded nibble for that digit.
// Optional feature macro SSD_RX_DP_EN adds decimal-point capture (i_DP/o_DP).
module ssd_rx
  import ssd_pkg::*;
#(
  parameter int N_DIGITS   = N_DIGITS_DEF,
  parameter int STABLE_CNT = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic [N_DIGITS-1:0]   i_Anodes,
  input  logic [6:0]            i_Cathodes,
  input  logic                  i_Clr,
  output logic [4*N_DIGITS-1:0] o_Digits,
  output logic [N_DIGITS-1:0]   o_DigValid,
  output logic                  o_Upd,
  output logic [3:0]            o_UpdIdx,
  output logic                  o_Err
`ifdef SSD_RX_DP_EN
  ,
  input  logic                  i_DP,
  output logic [N_DIGITS-1:0]   o_DP
`endif
);

  localparam logic [7:0] STB = 8'(STABLE_CNT);

  logic [N_DIGITS-1:0] an_p0, an_p1;
  logic [6:0]          cat_p0, cat_p1;
  logic [4:0]          nzero;
  logic [3:0]          idx;
  logic                qual;
  logic                match;
  logic [7:0]          cnt_p2, cnt_nxt;
  logic [3:0]          prev_idx_p2;
  logic [6:0]          prev_seg_p2;
  logic                commit;
  logic [3:0]          nib;
  logic                hit, blank;

  // Stage p0/p1: two-flop synchronisers, idle (all ones) in reset
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      an_p0  <= '1;
      an_p1  <= '1;
      cat_p0 <= '1;
      cat_p1 <= '1;
    end else begin
      an_p0  <= i_Anodes;
      an_p1  <= an_p0;
      cat_p0 <= i_Cathodes;
      cat_p1 <= cat_p0;
    end
  end

`ifdef SSD_RX_DP_EN
  logic dp_p0, dp_p1, prev_dp_p2;

  // Decimal point synchroniser, same depth as the segment bus
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      dp_p0 <= 1'b1;
      dp_p1 <= 1'b1;
    end else begin
      dp_p0 <= i_DP;
      dp_p1 <= dp_p0;
    end
  end
`endif

  // Qualify the sample: exactly one active anode, and find its index
  always_comb begin
    nzero = '0;
    idx   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_p1[i]) begin
        nzero = nzero + 5'd1;
        idx   = 4'(i);
      end
    end
    qual = (nzero == 5'd1);
  end

  // Stability counter next value; commit only on the transition into STB
  always_comb begin
    match = (idx == prev_idx_p2) && (cat_p1 == prev_seg_p2);
`ifdef SSD_RX_DP_EN
    match = match && (dp_p1 == prev_dp_p2);
`endif
    cnt_nxt = '0;
    if (qual) begin
      if (match) cnt_nxt = (cnt_p2 == STB) ? cnt_p2 : cnt_p2 + 8'd1;
      else       cnt_nxt = 8'd1;
    end
    commit = qual && (cnt_nxt == STB) && (cnt_p2 != STB);
  end

  // Stage p2: counter and last qualified pair
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      cnt_p2      <= '0;
      prev_idx_p2 <= '0;
      prev_seg_p2 <= '1;
    end else begin
      cnt_p2 <= cnt_nxt;
      if (qual) begin
        prev_idx_p2 <= idx;
        prev_seg_p2 <= cat_p1;
      end
    end
  end

`ifdef SSD_RX_DP_EN
  // Last qualified decimal point, part of the stability comparison
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) prev_dp_p2 <= 1'b1;
    else if (qual) prev_dp_p2 <= dp_p1;
  end
`endif

  ssd_seg2hex u_seg2hex (
    .seg   (cat_p1),
    .nib   (nib),
    .hit   (hit),
    .blank (blank)
  );

  // Output registers: commit writes digit state, clear overrides the flags
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_Digits   <= '0;
      o_DigValid <= '0;
      o_Upd      <= 1'b0;
      o_UpdIdx   <= '0;
      o_Err      <= 1'b0;
    end else begin
      o_Upd <= commit;
      if (commit) o_UpdIdx <= idx;
      for (int d = 0; d < N_DIGITS; d++) begin
        if (commit && (idx == 4'(d))) begin
          if (hit) begin
            o_Digits[4*d +: 4] <= nib;
            o_DigValid[d]      <= 1'b1;
          end else begin
            o_DigValid[d]      <= 1'b0;
          end
        end
      end
      if (commit && !hit && !blank) o_Err <= 1'b1;
      if (i_Clr) begin
        o_DigValid <= '0;
        o_Err      <= 1'b0;
      end
    end
  end

`ifdef SSD_RX_DP_EN
  // Decimal point is recaptured (active-high) on every commit of its digit
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_DP <= '0;
    end else begin
      for (int d = 0; d < N_DIGITS; d++) begin
        if (commit && (idx == 4'(d))) o_DP[d] <= ~dp_p1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ssd_rx.sv
// Directed bench for ssd_rx with default parameters (8 digits, STABLE_CNT=4).
module tb_ssd_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  anodes;
  logic [6:0]  cath;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  dig_valid;
  logic        upd;
  logic [3:0]  upd_idx;
  logic        err;
`ifdef SSD_RX_DP_EN
  logic        dp = 1'b1;
  logic [7:0]  dp_out;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int upd_total = 0;
  logic [3:0] last_idx = '0;

  always #5 clk = ~clk;

  ssd_rx #(.N_DIGITS(8), .STABLE_CNT(4)) dut (
    .i_CLK      (clk),
    .i_RSTn     (rst_n),
    .i_Anodes   (anodes),
    .i_Cathodes (cath),
    .i_Clr      (clr),
    .o_Digits   (digits),
    .o_DigValid (dig_valid),
    .o_Upd      (upd),
    .o_UpdIdx   (upd_idx),
    .o_Err      (err)
`ifdef SSD_RX_DP_EN
    ,
    .i_DP       (dp),
    .o_DP       (dp_out)
`endif
  );

  // Count update pulses on the inactive edge
  always @(negedge clk) begin
    if (upd) begin
      upd_total = upd_total + 1;
      last_idx  = upd_idx;
    end
  end

  typedef struct {
    logic [7:0] an;
    logic [6:0] cat;
    int         hold;
    int         exp_upd;
    logic [3:0] idx;
    logic [3:0] nib;
    logic       vld;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  initial begin
    int base;
    logic [31:0] scan_val;

    //           anodes        cathodes     hold upd idx  nib  vld  err
    vecs[0] = '{8'b11111110, 7'b0100100, 10, 1, 4'd0, 4'h2, 1'b1, 1'b0}; // digit0 = 2
    vecs[1] = '{8'b11110011, 7'b1000000, 20, 0, 4'd0, 4'h0, 1'b0, 1'b0}; // two anodes low
    vecs[2] = '{8'b11111101, 7'b1111001,  3, 0, 4'd0, 4'h0, 1'b0, 1'b0}; // one sample short
    vecs[3] = '{8'b11111101, 7'b1111001,  4, 1, 4'd1, 4'h1, 1'b1, 1'b0}; // exactly stable
    vecs[4] = '{8'b11111110, 7'b1111111,  8, 1, 4'd0, 4'h2, 1'b0, 1'b0}; // blank keeps nibble
    vecs[5] = '{8'b01111111, 7'b0001110,  8, 1, 4'd7, 4'hF, 1'b1, 1'b0}; // digit7 = F
    vecs[6] = '{8'b11111100, 7'b0000000,  8, 0, 4'd0, 4'h0, 1'b0, 1'b0}; // adjacent pair low
    vecs[7] = '{8'b11011111, 7'b1010101,  8, 1, 4'd5, 4'h0, 1'b0, 1'b1}; // bad glyph

    rst_n  = 1'b0;
    anodes = '1;
    cath   = '1;
    clr    = 1'b0;
    tick(3);
    chk("rst_digits", digits, 32'h0);
    chk("rst_valid", {24'h0, dig_valid}, 32'h0);
    chk("rst_upd", {31'h0, upd}, 32'h0);
    chk("rst_idx", {28'h0, upd_idx}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    for (int v = 0; v < 8; v++) begin
      base   = upd_total;
      anodes = vecs[v].an;
      cath   = vecs[v].cat;
      tick(vecs[v].hold);
      anodes = '1;
      cath   = '1;
      tick(4);
      chk($sformatf("v%0d_upd_count", v), 32'(upd_total - base), 32'(vecs[v].exp_upd));
      if (vecs[v].exp_upd > 0) begin
        chk($sformatf("v%0d_upd_idx", v), {28'h0, last_idx}, {28'h0, vecs[v].idx});
        chk($sformatf("v%0d_nibble", v), (digits >> (4 * vecs[v].idx)) & 32'hF, {28'h0, vecs[v].nib});
        chk($sformatf("v%0d_valid", v), {31'h0, dig_valid[vecs[v].idx]}, {31'h0, vecs[v].vld});
      end
      chk($sformatf("v%0d_err", v), {31'h0, err}, {31'h0, vecs[v].err});
    end

    // Clear drops flags but keeps nibbles
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_err", {31'h0, err}, 32'h0);
    chk("clr_valid", {24'h0, dig_valid}, 32'h0);
    chk("clr_digit0", {28'h0, digits[3:0]}, 32'h2);
    chk("clr_digit7", {28'h0, digits[31:28]}, 32'hF);

    // Full scan, 8 cycles per digit
    scan_val = 32'h1234ABCF;
    base = upd_total;
    for (int d = 0; d < 8; d++) begin
      anodes = ~(8'b1 << d);
      cath   = seg_of(4'((scan_val >> (4 * d)) & 32'hF));
      tick(8);
    end
    anodes = '1;
    cath   = '1;
    tick(4);
    chk("scan_digits", digits, 32'h1234ABCF);
    chk("scan_valid", {24'h0, dig_valid}, 32'hFF);
    chk("scan_upd_count", 32'(upd_total - base), 32'd8);
    chk("scan_err", {31'h0, err}, 32'h0);

    // Reset while the counter sits at 3 abandons the commit
    base   = upd_total;
    anodes = 8'b11111011;
    cath   = 7'b0110000;
    tick(5);
    rst_n = 1'b0;
    #2;
    chk("midrst_upd", {31'h0, upd}, 32'h0);
    chk("midrst_valid", {24'h0, dig_valid}, 32'h0);
    chk("midrst_digits", digits, 32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("midrst_no_upd", 32'(upd_total - base), 32'd0);
    chk("midrst_upd_low", {31'h0, upd}, 32'h0);
    tick(1);
    chk("midrst_upd_high", {31'h0, upd}, 32'h1);
    chk("midrst_idx", {28'h0, upd_idx}, 32'd2);
    chk("midrst_digit2", {28'h0, digits[11:8]}, 32'h3);
    chk("midrst_valid2", {31'h0, dig_valid[2]}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
